biriscv_multiplier_unit: RTL and testbench

//  RV32M multiply unit (MUL/MULH/MULHSU/MULHU) for the biRISC-V execute pipeline.

---
 rtl/biriscv_defs_pkg.sv | 31 +++
 rtl/biriscv_mul_decode.sv | 24 ++
 rtl/biriscv_multiplier_unit.sv | 78 +++++++
 tb/tb_biriscv_multiplier_unit.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/biriscv_defs_pkg.sv
// Shared RV32M multiply definitions: instruction match/mask constants, op select and E1 stage record.
package biriscv_defs_pkg;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  // Match values compare against the instruction ANDed with the mask (funct7 + funct3 + opcode).
  localparam logic [31:0] INST_MUL_MASK   = 32'hfe00707f;
  localparam logic [31:0] INST_MUL        = {FUNCT7_MULDIV, 10'b0, 3'b000, 5'b0, OPCODE_OP};
  localparam logic [31:0] INST_MULH       = {FUNCT7_MULDIV, 10'b0, 3'b001, 5'b0, OPCODE_OP};
  localparam logic [31:0] INST_MULHSU     = {FUNCT7_MULDIV, 10'b0, 3'b010, 5'b0, OPCODE_OP};
  localparam logic [31:0] INST_MULHU      = {FUNCT7_MULDIV, 10'b0, 3'b011, 5'b0, OPCODE_OP};
  localparam logic [31:0] INST_MULH_MASK   = INST_MUL_MASK;
  localparam logic [31:0] INST_MULHSU_MASK = INST_MUL_MASK;
  localparam logic [31:0] INST_MULHU_MASK  = INST_MUL_MASK;

  typedef enum logic [2:0] {
    MUL_OP_NONE,
    MUL_OP_MUL,
    MUL_OP_MULH,
    MUL_OP_MULHSU,
    MUL_OP_MULHU
  } mul_op_e;

  typedef struct packed {
    logic [32:0] operand_a;
    logic [32:0] operand_b;
    logic        sel_high;
  } e1_t;

endpackage

// File: rtl/biriscv_mul_decode.sv
// Instruction word -> multiply op select; non-mul or invalid slots decode to MUL_OP_NONE.
module biriscv_mul_decode
  import biriscv_defs_pkg::*;
(
  input  logic        valid_i,
  input  logic [31:0] opcode_i,
  output mul_op_e     op_o
);

  always_comb begin
    op_o = MUL_OP_NONE;
    if (valid_i) begin
      if ((opcode_i & INST_MUL_MASK) == INST_MUL)
        op_o = MUL_OP_MUL;
      else if ((opcode_i & INST_MULH_MASK) == INST_MULH)
        op_o = MUL_OP_MULH;
      else if ((opcode_i & INST_MULHSU_MASK) == INST_MULHSU)
        op_o = MUL_OP_MULHSU;
      else if ((opcode_i & INST_MULHU_MASK) == INST_MULHU)
        op_o = MUL_OP_MULHU;
    end
  end

endmodule

// File: rtl/biriscv_multiplier_unit.sv
// RV32M multiply unit: E1 captures extended operands, E2 registers the selected product half.
// Define BIRISCV_MUL_EXTRA_STAGE_EN to add an E3 output register (latency 3 instead of 2).
module biriscv_multiplier_unit
  import biriscv_defs_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        opcode_valid_i,
  input  logic [31:0] opcode_opcode_i,
  input  logic [31:0] opcode_ra_operand_i,
  input  logic [31:0] opcode_rb_operand_i,
  input  logic        hold_i,
  output logic [31:0] writeback_value_o
);

  mul_op_e     op;
  e1_t         e1_d, e1_q;
  logic [63:0] product;
  logic [31:0] result_d, result_q;

  biriscv_mul_decode u_decode (
    .valid_i  (opcode_valid_i),
    .opcode_i (opcode_opcode_i),
    .op_o     (op)
  );

  // Idle or non-mul slots load zeros so the output drains to 0.
  always_comb begin
    e1_d = e1_q;
    if (!hold_i) begin
      e1_d = '0;
      if (op != MUL_OP_NONE) begin
        e1_d.operand_a = {((op == MUL_OP_MULH) || (op == MUL_OP_MULHSU)) & opcode_ra_operand_i[31],
                          opcode_ra_operand_i};
        e1_d.operand_b = {(op == MUL_OP_MULH) & opcode_rb_operand_i[31], opcode_rb_operand_i};
        e1_d.sel_high  = (op != MUL_OP_MUL);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) e1_q <= '0;
    else        e1_q <= e1_d;
  end

  // The low 64 bits of the sign-extended product equal the signed 33x33 result.
  assign product = {{31{e1_q.operand_a[32]}}, e1_q.operand_a} *
                   {{31{e1_q.operand_b[32]}}, e1_q.operand_b};

  always_comb begin
    result_d = result_q;
    if (!hold_i)
      result_d = e1_q.sel_high ? product[63:32] : product[31:0];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) result_q <= '0;
    else        result_q <= result_d;
  end

`ifdef BIRISCV_MUL_EXTRA_STAGE_EN
  logic [31:0] wb_d, wb_q;

  always_comb begin
    wb_d = hold_i ? wb_q : result_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) wb_q <= '0;
    else        wb_q <= wb_d;
  end

  assign writeback_value_o = wb_q;
`else
  assign writeback_value_o = result_q;
`endif

endmodule

// File: tb/tb_biriscv_multiplier_unit.sv
// Directed bench for biriscv_multiplier_unit; expected pipeline contents tracked in exp_q.
module tb_biriscv_multiplier_unit;

`ifdef BIRISCV_MUL_EXTRA_STAGE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        opcode_valid_i;
  logic [31:0] opcode_opcode_i;
  logic [31:0] opcode_ra_operand_i;
  logic [31:0] opcode_rb_operand_i;
  logic        hold_i;
  logic [31:0] writeback_value_o;

  logic [31:0] exp_q[$];
  logic [31:0] cur_exp;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk_i = ~clk_i;

  biriscv_multiplier_unit dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .opcode_valid_i      (opcode_valid_i),
    .opcode_opcode_i     (opcode_opcode_i),
    .opcode_ra_operand_i (opcode_ra_operand_i),
    .opcode_rb_operand_i (opcode_rb_operand_i),
    .hold_i              (hold_i),
    .writeback_value_o   (writeback_value_o)
  );

  function automatic logic [31:0] mk_inst(input logic [6:0] funct7, input logic [2:0] funct3,
                                          input logic [6:0] opc);
    return {funct7, 5'd2, 5'd1, funct3, 5'd3, opc};
  endfunction

  // Pipeline model: each non-held edge pushes the hand-computed value for the slot just taken.
  task automatic tick();
    @(posedge clk_i);
    if (!rst_i) begin
      exp_q.delete();
      for (int i = 0; i < LAT; i++) exp_q.push_back(32'h0);
    end else if (!hold_i) begin
      exp_q.push_back(cur_exp);
      void'(exp_q.pop_front());
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_val);
    opcode_valid_i      = v;
    opcode_opcode_i     = inst;
    opcode_ra_operand_i = a;
    opcode_rb_operand_i = b;
    cur_exp             = exp_val;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic check(input string tag);
    vectors++;
    assert (writeback_value_o === exp_q[0])
    else begin
      miscompares++;
      $error("FAIL %s: observed %08h expected %08h", tag, writeback_value_o, exp_q[0]);
    end
  endtask

  localparam logic [6:0] F7 = 7'b0000001;
  localparam logic [6:0] OP = 7'b0110011;

  initial begin
    for (int i = 0; i < LAT; i++) exp_q.push_back(32'h0);
    rst_i  = 1'b0;
    hold_i = 1'b0;
    idle();
    tick();
    tick();
    check("reset");
    rst_i = 1'b1;

    // Back-to-back stream; every edge checks the result of the slot LAT edges earlier.
    drive(1'b1, mk_inst(F7, 3'b000, OP), 32'h80000001, 32'h80010002, 32'h80010002); tick(); check("s_mul_a");
    drive(1'b1, mk_inst(F7, 3'b001, OP), 32'h80000001, 32'h80010002, 32'h3FFF7FFE); tick(); check("s_mulh_a");
    drive(1'b1, mk_inst(F7, 3'b010, OP), 32'h80000001, 32'h80010002, 32'hBFFF7FFF); tick(); check("s_mulhsu_a");
    drive(1'b1, mk_inst(F7, 3'b011, OP), 32'h80000001, 32'h80010002, 32'h40008001); tick(); check("s_mulhu_a");
    drive(1'b1, mk_inst(F7, 3'b000, OP), 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001); tick(); check("s_mul_ff");
    drive(1'b1, mk_inst(F7, 3'b001, OP), 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000); tick(); check("s_mulh_ff");
    drive(1'b1, mk_inst(F7, 3'b010, OP), 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF); tick(); check("s_mulhsu_ff");
    drive(1'b1, mk_inst(F7, 3'b011, OP), 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE); tick(); check("s_mulhu_ff");
    drive(1'b1, mk_inst(F7, 3'b100, OP), 32'h12345678, 32'h00000003, 32'h00000000); tick(); check("s_div");
    drive(1'b0, mk_inst(F7, 3'b000, OP), 32'h12345678, 32'h00000003, 32'h00000000); tick(); check("s_invalid");
    drive(1'b1, mk_inst(F7, 3'b000, 7'b0010011), 32'h5, 32'h6, 32'h00000000);       tick(); check("s_not_op");
    drive(1'b1, mk_inst(F7, 3'b001, OP), 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF); tick(); check("s_mulh_neg");
    drive(1'b1, mk_inst(F7, 3'b010, OP), 32'h00000002, 32'hFFFFFFFF, 32'h00000001); tick(); check("s_mulhsu_pos");
    drive(1'b1, mk_inst(F7, 3'b000, OP), 32'd7, 32'd9, 32'h0000003F);               tick(); check("s_mul_7x9");
    idle();
    for (int i = 0; i < LAT + 1; i++) begin
      tick();
      check("drain");
    end

    // Hold: garbage inputs while held must not enter, output must freeze.
    drive(1'b1, mk_inst(F7, 3'b011, OP), 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE); tick(); check("h_mulhu");
    drive(1'b1, mk_inst(F7, 3'b000, OP), 32'd7, 32'd9, 32'h0000003F);               tick(); check("h_mul");
    hold_i = 1'b1;
    drive(1'b1, mk_inst(F7, 3'b001, OP), 32'h80000001, 32'h80010002, 32'h3FFF7FFE);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("held");
    end
    hold_i = 1'b0;
    idle();
    for (int i = 0; i < LAT + 1; i++) begin
      tick();
      check("h_release");
    end

    // Reset overriding hold mid-flight discards everything in the pipe.
    drive(1'b1, mk_inst(F7, 3'b000, OP), 32'd7, 32'd9, 32'h0000003F);               tick(); check("r_mul");
    drive(1'b1, mk_inst(F7, 3'b011, OP), 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE); tick(); check("r_mulhu");
    hold_i = 1'b1;
    rst_i  = 1'b0;
    tick();
    check("r_reset_hold");
    rst_i  = 1'b1;
    hold_i = 1'b0;
    idle();
    for (int i = 0; i < LAT + 1; i++) begin
      tick();
      check("r_after");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
